display_source_arbiter: RTL and testbench
=========================================

# display_source_arbiter

Shares the single four-digit seven-segment display path between three BCD sources (e.g., counter, clock, message). Grants one requester at a time using round-robin arbitration and a guaranteed minimum on-screen time. Presents the winner's 16-bit BCD word, registered, to the display controller. Shows a blank pattern when no source requests.

## Interface
- HOLD_CYCLES, default 1000: minimum clk cycles a granted source owns the display; legal range 1..65535.
- IDLE_BCD, default 16'hFFFF: word driven on bcd_out when no grant is active (non-BCD nibbles decode to blank).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  3  per-source request, level-sensitive; bit i is source i.
- bcd0, bcd1, bcd2  in  16 each  source BCD words, four nibbles, digit 0 in [3:0].
- grant  out  3  one-hot owner; all-zero when idle.
- bcd_out  out  16  registered copy of the owner's word, or IDLE_BCD; feeds the display controller BCD input.
- busy  out  1  high while any grant is active.
- switch_pulse  out  1  one-cycle pulse on every cycle grant changes value, including to and from idle.

## Operation
- States:
  - IDLE: no owner.
  - HOLD: owner granted, hold counter running.
  - OWN: hold expired, owner retained.
- Round-robin pointer last[1:0] holds the most recent owner. The winner is the first asserted req bit searching last+1, last+2, last+3 (mod 3).
- IDLE: if req is nonzero, grant the winner, load the hold counter with HOLD_CYCLES-1, and go to HOLD. Otherwise stay in IDLE.
- HOLD:
  - Counter decrements each cycle.
  - The owner's req is ignored, so dropping it early does not shorten the hold.
  - When the counter is 0, go to OWN.
  - Grant cannot change in HOLD.
- OWN, evaluated every cycle. The first matching rule applies:
  1. Another source requests: grant the round-robin winner among the other sources. This applies even if the owner still requests. Reload the counter and go to HOLD.
  2. Owner req is low and no other request: clear grant and go to IDLE.
  3. Otherwise, the owner keeps the grant and stays in OWN.
- last updates to the new owner on every grant. It is unchanged on the transition to IDLE.
- bcd_out: each cycle, registers the bcd input selected by the grant value of the next state, or IDLE_BCD if that next grant is zero. Source data changing during ownership therefore appears on bcd_out with 1-cycle latency.
- busy = |grant (registered).
- switch_pulse = (next grant != current grant), registered alongside grant.
- Hold counter is 16 bits with no wrap: it loads HOLD_CYCLES-1 and stops at 0.
- Grant is always one-hot or zero; two bits are never high together.

## Timing
- Reset values (rst=0 at a clock edge):
  - state=IDLE, grant=3'b000, bcd_out=IDLE_BCD, busy=0, switch_pulse=0.
  - last=2, so source 0 has first priority.
  - Counter = 0.
- Reset asserted mid-HOLD or mid-OWN: all of the above take effect at that edge, with no completion of the hold.
- Request latency: req seen in IDLE at edge t, so grant, busy, bcd_out and switch_pulse are valid after edge t.
- Minimum ownership: grant is stable for exactly HOLD_CYCLES cycles in HOLD, then at least one cycle in OWN before a switch. Total minimum is HOLD_CYCLES+1 cycles.
- HOLD_CYCLES=1: HOLD lasts 1 cycle.
- Simultaneous requests from IDLE after reset: source 0 wins, then 1, then 2.
- Handover: the OWN-cycle evaluation at edge t produces the new grant and new bcd_out after edge t. There is no idle gap between owners.
- A req pulse shorter than one cycle that falls between edges is not seen; this is acceptable.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with req=3'b111, then release. Required: outputs at reset values while rst=0; grant=001 one cycle after release, bcd_out=bcd0, switch_pulse=1 for one cycle.
- **Minimum hold:** HOLD_CYCLES=4; req0 held, req1 raised 1 cycle after grant0. Required: grant0 for exactly 5 cycles, then grant=010 and bcd_out=bcd1 the next cycle.
- **Rotation fairness:** req=111 held continuously. Required: grant sequence 001,010,100,001,… with each segment HOLD_CYCLES+1 cycles long.
- **Release to idle:** req0 only, dropped during HOLD. Required: grant held until HOLD ends, then one OWN cycle, then grant=000, bcd_out=16'hFFFF, busy=0.
- **Live data:** source 2 owns the display and bcd2 changes 1234→5678. Required: bcd_out=5678 one cycle later with grant unchanged.
- **Mid-operation reset:** rst=0 during OWN of source 1. Required: grant=000 and bcd_out=IDLE_BCD on the next edge; after release with req=110, source 1 is granted first (last=2 after reset).

Source files
------------

// File: rtl/display_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : display_source_arbiter
// Description : Round-robin owner selection, with a minimum on-screen time,
//               for three BCD sources sharing one four-digit display.
// Revision    : 1.0 - initial release
// ============================================================================
module display_source_arbiter #(
    parameter int          HOLD_CYCLES = 1000,
    parameter logic [15:0] IDLE_BCD    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] bcd0,
    input  logic [15:0] bcd1,
    input  logic [15:0] bcd2,
    output logic [2:0]  grant,
    output logic [15:0] bcd_out,
    output logic        busy,
    output logic        switch_pulse
);

    localparam logic [15:0] c_hold_load = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_OWN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  r_last;
    logic [1:0]  w_last_nxt;
    logic [2:0]  r_grant;
    logic [2:0]  w_grant_nxt;
    logic [2:0]  w_others;
    logic [15:0] r_bcd_out;
    logic [15:0] w_bcd_nxt;
    logic        r_busy;
    logic        r_switch;

    // First asserted bit searching last+1, last+2, last+3 (mod 3).
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % 3);
            if (r[idx]) begin
                pick = 3'b001 << idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_others    = req & ~r_grant;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_nxt = rr_pick(req, r_last);
                    w_last_nxt  = onehot_idx(w_grant_nxt);
                    w_cnt_nxt   = c_hold_load;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_OWN;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_OWN: begin
                // The owner is masked out, so its own request never blocks a handover.
                if (|w_others) begin
                    w_grant_nxt = rr_pick(w_others, r_last);
                    w_last_nxt  = onehot_idx(w_grant_nxt);
                    w_cnt_nxt   = c_hold_load;
                    w_state_nxt = S_HOLD;
                end else if (~|(req & r_grant)) begin
                    w_grant_nxt = 3'b000;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_grant_nxt = 3'b000;
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_grant_nxt)
            3'b001:  w_bcd_nxt = bcd0;
            3'b010:  w_bcd_nxt = bcd1;
            3'b100:  w_bcd_nxt = bcd2;
            default: w_bcd_nxt = IDLE_BCD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_last    <= 2'd2;
            r_grant   <= 3'b000;
            r_bcd_out <= IDLE_BCD;
            r_busy    <= 1'b0;
            r_switch  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_grant   <= w_grant_nxt;
            r_bcd_out <= w_bcd_nxt;
            r_busy    <= |w_grant_nxt;
            r_switch  <= (w_grant_nxt != r_grant);
        end
    end

    assign grant        = r_grant;
    assign bcd_out      = r_bcd_out;
    assign busy         = r_busy;
    assign switch_pulse = r_switch;

endmodule
`default_nettype wire

// File: tb/tb_display_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_source_arbiter
// Description : Directed and randomized checks of display_source_arbiter
//               against an ownership/age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_source_arbiter;

    localparam int          HOLD = 4;
    localparam logic [15:0] IDLE = 16'hFFFF;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] bcd0;
    logic [15:0] bcd1;
    logic [15:0] bcd2;
    logic [2:0]  grant;
    logic [15:0] bcd_out;
    logic        busy;
    logic        switch_pulse;

    int n_cmp;
    int n_err;

    // Reference model: who owns the display and for how many cycles so far.
    int          m_owner;
    int          m_held;
    int          m_last;
    logic [2:0]  m_grant;
    logic [15:0] m_bcd;
    logic        m_busy;
    logic        m_sw;

    display_source_arbiter #(
        .HOLD_CYCLES (HOLD),
        .IDLE_BCD    (IDLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .bcd0         (bcd0),
        .bcd1         (bcd1),
        .bcd2         (bcd2),
        .grant        (grant),
        .bcd_out      (bcd_out),
        .busy         (busy),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [2:0] r, input int lst);
        for (int k = 1; k <= 3; k++) begin
            if (r[(lst + k) % 3]) return (lst + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [15:0] src_word(input int s);
        if (s == 0) return bcd0;
        if (s == 1) return bcd1;
        return bcd2;
    endfunction

    task automatic model_step();
        logic [2:0] prev;
        logic [2:0] others;
        int         w;
        prev = m_grant;
        if (!rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 2;
            m_grant = 3'b000;
            m_bcd   = IDLE;
            m_busy  = 1'b0;
            m_sw    = 1'b0;
            return;
        end
        if (m_owner < 0) begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_last  = w;
            end
        end else if (m_held <= HOLD) begin
            m_held++;
        end else begin
            others = req & ~(3'b001 << m_owner);
            if (others != 3'b000) begin
                w       = pick(others, m_owner);
                m_owner = w;
                m_held  = 1;
                m_last  = w;
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
        m_grant = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
        m_bcd   = (m_owner < 0) ? IDLE : src_word(m_owner);
        m_busy  = (m_owner >= 0);
        m_sw    = (m_grant != prev);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = 3'b000;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (grant !== 3'b000 || bcd_out !== IDLE || busy !== 1'b0 || switch_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: grant=%b bcd=%h busy=%b sw=%b required 000/%h/0/0",
                         grant, bcd_out, busy, switch_pulse, IDLE);
            end
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (grant !== 3'b001 || bcd_out !== bcd0 || busy !== 1'b1 || switch_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: grant=%b bcd=%h busy=%b sw=%b required 001/%h/1/1",
                     grant, bcd_out, busy, switch_pulse, bcd0);
        end
        tick();
        n_cmp++;
        if (switch_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulse_width: sw=%b required 0", switch_pulse);
        end
    endtask

    task automatic test_min_hold();
        int n;
        do_reset();
        req = 3'b001;
        tick();
        n = 1;
        req = 3'b011;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant !== 3'b001) break;
            n++;
        end
        n_cmp++;
        if (n !== HOLD + 1) begin
            n_err++;
            $display("FAIL min_hold_len: cycles=%0d required %0d", n, HOLD + 1);
        end
        n_cmp++;
        if (grant !== 3'b010 || bcd_out !== bcd1 || switch_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL min_hold_handover: grant=%b bcd=%h sw=%b required 010/%h/1",
                     grant, bcd_out, switch_pulse, bcd1);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_g;
        int         len;
        do_reset();
        req = 3'b111;
        tick();
        for (int s = 0; s < 6; s++) begin
            exp_g = 3'b001 << (s % 3);
            n_cmp++;
            if (grant !== exp_g || grant !== m_grant) begin
                n_err++;
                $display("FAIL rotation_owner[%0d]: grant=%b required %b", s, grant, exp_g);
            end
            len = 1;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (grant !== exp_g) break;
                len++;
            end
            n_cmp++;
            if (len !== HOLD + 1) begin
                n_err++;
                $display("FAIL rotation_len[%0d]: cycles=%0d required %0d", s, len, HOLD + 1);
            end
        end
    endtask

    task automatic test_release();
        int n;
        do_reset();
        req = 3'b001;
        tick();
        n = 1;
        tick();
        n++;
        req = 3'b000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant !== 3'b001) break;
            n++;
        end
        n_cmp++;
        if (n !== HOLD + 1) begin
            n_err++;
            $display("FAIL release_len: cycles=%0d required %0d", n, HOLD + 1);
        end
        n_cmp++;
        if (grant !== 3'b000 || bcd_out !== 16'hFFFF || busy !== 1'b0 || switch_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL release_idle: grant=%b bcd=%h busy=%b sw=%b required 000/ffff/0/1",
                     grant, bcd_out, busy, switch_pulse);
        end
    endtask

    task automatic test_live_data();
        do_reset();
        bcd2 = 16'h1234;
        req  = 3'b100;
        tick();
        n_cmp++;
        if (grant !== 3'b100 || bcd_out !== 16'h1234) begin
            n_err++;
            $display("FAIL live_first: grant=%b bcd=%h required 100/1234", grant, bcd_out);
        end
        for (int i = 0; i < HOLD + 3; i++) tick();
        bcd2 = 16'h5678;
        n_cmp++;
        if (bcd_out !== 16'h1234) begin
            n_err++;
            $display("FAIL live_before: bcd=%h required 1234", bcd_out);
        end
        tick();
        n_cmp++;
        if (grant !== 3'b100 || bcd_out !== 16'h5678 || switch_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL live_update: grant=%b bcd=%h sw=%b required 100/5678/0",
                     grant, bcd_out, switch_pulse);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 3'b010;
        for (int i = 0; i < HOLD + 3; i++) tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 3'b000 || bcd_out !== IDLE || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: grant=%b bcd=%h busy=%b required 000/%h/0",
                     grant, bcd_out, busy, IDLE);
        end
        rst = 1'b1;
        req = 3'b110;
        tick();
        n_cmp++;
        if (grant !== 3'b010 || bcd_out !== bcd1) begin
            n_err++;
            $display("FAIL mid_reset_first: grant=%b bcd=%h required 010/%h", grant, bcd_out, bcd1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = 3'($urandom);
            if ($urandom_range(0, 5) == 0) bcd0 = 16'($urandom);
            if ($urandom_range(0, 5) == 0) bcd1 = 16'($urandom);
            if ($urandom_range(0, 5) == 0) bcd2 = 16'($urandom);
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if (grant !== m_grant || bcd_out !== m_bcd || busy !== m_busy || switch_pulse !== m_sw) begin
                n_err++;
                $display("FAIL random[%0d]: grant=%b bcd=%h busy=%b sw=%b required %b/%h/%b/%b",
                         i, grant, bcd_out, busy, switch_pulse, m_grant, m_bcd, m_busy, m_sw);
            end
            n_cmp++;
            if (!$onehot0(grant)) begin
                n_err++;
                $display("FAIL random_onehot[%0d]: grant=%b required one-hot or zero", i, grant);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        m_owner = -1;
        m_held  = 0;
        m_last  = 2;
        m_grant = 3'b000;
        m_bcd   = IDLE;
        m_busy  = 1'b0;
        m_sw    = 1'b0;
        rst     = 1'b0;
        req     = 3'b000;
        bcd0    = 16'h0123;
        bcd1    = 16'h4567;
        bcd2    = 16'h8901;
        test_reset();
        test_min_hold();
        test_rotation();
        test_release();
        test_live_data();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
